// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor: tagged table of saturating counters and targets,
// combinational lookup, one update per cycle, saturating mispredict counter.
// Optional feature macro: BP_GHR_EN (XOR a non-speculative global history into the index).
module branch_predictor #(
    parameter int unsigned PC_W    = 32,
    parameter int unsigned ENTRIES = 64,
    parameter int unsigned CTR_W   = 2,
    parameter int unsigned GHR_W   = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] lookup_pc,
    input  logic            lookup_is_branch,
    output logic            predict_taken,
    output logic [PC_W-1:0] predict_target,
    input  logic            update_valid,
    input  logic [PC_W-1:0] update_pc,
    input  logic            update_taken,
    input  logic [PC_W-1:0] update_target,
    input  logic            update_mispredict,
    output logic [15:0]     mispredict_cnt
);
    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = PC_W - IDX_W - 2;
    localparam logic [CTR_W-1:0] CtrWeakT  = CTR_W'(1 << (CTR_W - 1));
    localparam logic [CTR_W-1:0] CtrWeakNt = CTR_W'((1 << (CTR_W - 1)) - 1);
    localparam logic [CTR_W-1:0] CtrMax    = '1;

    if (ENTRIES < 4 || (ENTRIES & (ENTRIES - 1)) != 0) begin : g_bad_entries
        $error("branch_predictor: ENTRIES must be a power of two >= 4");
    end
    if (CTR_W < 1 || CTR_W > 4) begin : g_bad_ctr_w
        $error("branch_predictor: CTR_W must be in 1..4");
    end
    if (PC_W <= IDX_W + 2) begin : g_bad_pc_w
        $error("branch_predictor: PC_W too small for ENTRIES");
    end

    logic             valid_q [ENTRIES];
    logic             valid_d [ENTRIES];
    logic [CTR_W-1:0] ctr_q   [ENTRIES];
    logic [CTR_W-1:0] ctr_d   [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    logic [TAG_W-1:0] tag_d   [ENTRIES];
    logic [PC_W-1:0]  tgt_q   [ENTRIES];
    logic [PC_W-1:0]  tgt_d   [ENTRIES];
    logic [15:0]      cnt_q, cnt_d;

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             lk_hit, up_hit;

    // Low PC bits are never part of index or tag.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{lookup_pc[1:0], update_pc[1:0]};

`ifdef BP_GHR_EN
    if (GHR_W < 1 || GHR_W > IDX_W) begin : g_bad_ghr_w
        $error("branch_predictor: GHR_W must be in 1..log2(ENTRIES)");
    end

    logic [GHR_W-1:0] ghr_q, ghr_d;

    // Both lookup and update hash with the current (pre-update) history.
    assign lk_idx = lookup_pc[IDX_W+1:2] ^ IDX_W'(ghr_q);
    assign up_idx = update_pc[IDX_W+1:2] ^ IDX_W'(ghr_q);

    // History shifts in the resolved outcome at the LSB on every update.
    always_comb begin
        ghr_d = ghr_q;
        if (update_valid) begin
            ghr_d = GHR_W'({ghr_q, update_taken});
        end
    end

    // History register, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end
`else
    localparam int unsigned unused_ghr_w = GHR_W;

    assign lk_idx = lookup_pc[IDX_W+1:2];
    assign up_idx = update_pc[IDX_W+1:2];
`endif

    assign lk_tag = lookup_pc[PC_W-1:IDX_W+2];
    assign up_tag = update_pc[PC_W-1:IDX_W+2];
    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    // Zero-latency prediction from the registered table (no same-cycle bypass).
    always_comb begin
        predict_taken  = lookup_is_branch && lk_hit && ctr_q[lk_idx][CTR_W-1];
        predict_target = predict_taken ? tgt_q[lk_idx] : lookup_pc + PC_W'(4);
        mispredict_cnt = cnt_q;
    end

    // Table next state: train on hit, allocate (evicting) on miss.
    always_comb begin
        valid_d = valid_q;
        ctr_d   = ctr_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        if (update_valid) begin
            valid_d[up_idx] = 1'b1;
            tag_d[up_idx]   = up_tag;
            if (up_hit) begin
                if (update_taken) begin
                    if (ctr_q[up_idx] != CtrMax) ctr_d[up_idx] = ctr_q[up_idx] + CTR_W'(1);
                end else if (ctr_q[up_idx] != '0) begin
                    ctr_d[up_idx] = ctr_q[up_idx] - CTR_W'(1);
                end
            end else begin
                ctr_d[up_idx] = update_taken ? CtrWeakT : CtrWeakNt;
            end
            if (update_taken) begin
                tgt_d[up_idx] = update_target;
            end
        end
    end

    // Mispredict counter next state, saturating at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (update_valid && update_mispredict && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Valid bits, counters and mispredict count; reset takes effect immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CtrWeakNt;
            end
            cnt_q <= '0;
        end else begin
            valid_q <= valid_d;
            ctr_q   <= ctr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Tags and targets are qualified by valid, so they need no reset.
    always_ff @(posedge clk) begin
        tag_q <= tag_d;
        tgt_q <= tgt_d;
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed literal checks plus a randomized
// run compared every cycle against a behavioural table model.
module tb_branch_predictor;
    localparam int unsigned PC_W    = 32;
    localparam int unsigned ENTRIES = 64;
    localparam int unsigned CTR_W   = 2;
`ifdef BP_GHR_EN
    localparam int unsigned GHR_W   = 2;
`else
    localparam int unsigned GHR_W   = 6;
`endif
    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int HALF = 1 << (CTR_W - 1);
    localparam int CMAX = (1 << CTR_W) - 1;

    logic            clk;
    logic            rst;
    logic [PC_W-1:0] lookup_pc;
    logic            lookup_is_branch;
    logic            predict_taken;
    logic [PC_W-1:0] predict_target;
    logic            update_valid;
    logic [PC_W-1:0] update_pc;
    logic            update_taken;
    logic [PC_W-1:0] update_target;
    logic            update_mispredict;
    logic [15:0]     mispredict_cnt;

    branch_predictor #(
        .PC_W    (PC_W),
        .ENTRIES (ENTRIES),
        .CTR_W   (CTR_W),
        .GHR_W   (GHR_W)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .lookup_pc         (lookup_pc),
        .lookup_is_branch  (lookup_is_branch),
        .predict_taken     (predict_taken),
        .predict_target    (predict_target),
        .update_valid      (update_valid),
        .update_pc         (update_pc),
        .update_taken      (update_taken),
        .update_target     (update_target),
        .update_mispredict (update_mispredict),
        .mispredict_cnt    (mispredict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Behavioural model: one record per table slot, counters as plain integers.
    bit              m_valid [ENTRIES];
    int unsigned     m_tag   [ENTRIES];
    int              m_ctr   [ENTRIES];
    logic [PC_W-1:0] m_tgt   [ENTRIES];
    int unsigned     m_cnt;
    int unsigned     m_ghr;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic int unsigned m_index(input logic [PC_W-1:0] pc);
        int unsigned i;
        i = int'(pc >> 2) % ENTRIES;
`ifdef BP_GHR_EN
        i = i ^ m_ghr;
`endif
        return i;
    endfunction

    function automatic int unsigned m_tagof(input logic [PC_W-1:0] pc);
        return int'(pc >> (IDX_W + 2));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < int'(ENTRIES); i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = HALF - 1;
            m_tag[i]   = 0;
            m_tgt[i]   = '0;
        end
        m_cnt = 0;
        m_ghr = 0;
    endtask

    task automatic model_update();
        int unsigned i;
        int unsigned t;
        if (!update_valid) return;
        i = m_index(update_pc);
        t = m_tagof(update_pc);
        if (m_valid[i] && m_tag[i] == t) begin
            if (update_taken) m_ctr[i] = (m_ctr[i] + 1 > CMAX) ? CMAX : m_ctr[i] + 1;
            else              m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
        end else begin
            m_valid[i] = 1'b1;
            m_tag[i]   = t;
            m_ctr[i]   = update_taken ? HALF : HALF - 1;
        end
        if (update_taken) m_tgt[i] = update_target;
        if (update_mispredict && m_cnt < 65535) m_cnt++;
        m_ghr = ((m_ghr << 1) | int'(update_taken)) % (1 << GHR_W);
    endtask

    task automatic compare();
        int unsigned     i;
        bit              hit;
        bit              tk;
        logic [PC_W-1:0] tg;
        i   = m_index(lookup_pc);
        hit = m_valid[i] && (m_tag[i] == m_tagof(lookup_pc));
        tk  = lookup_is_branch && hit && (m_ctr[i] >= HALF);
        tg  = tk ? m_tgt[i] : lookup_pc + 32'd4;
        check("model predict_taken", 32'(predict_taken), 32'(tk));
        check("model predict_target", predict_target, tg);
        check("model mispredict_cnt", 32'(mispredict_cnt), m_cnt);
    endtask

    task automatic settle();
        #1;
        compare();
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_update();
        @(negedge clk);
    endtask

    task automatic set_lk(input logic [PC_W-1:0] pc, input logic br);
        lookup_pc        = pc;
        lookup_is_branch = br;
    endtask

    task automatic set_up(input logic v, input logic [PC_W-1:0] pc, input logic t,
                          input logic [PC_W-1:0] tg, input logic m);
        update_valid      = v;
        update_pc         = pc;
        update_taken      = t;
        update_target     = tg;
        update_mispredict = m;
    endtask

    function automatic logic [PC_W-1:0] rand_pc();
        logic [PC_W-1:0] pc;
        pc = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2)
             | 32'($urandom_range(0, 3));
        if ($urandom_range(0, 15) == 0) pc = pc | 32'hFFFF_FF00;
        return pc;
    endfunction

    initial begin
        rst = 1'b1;
        set_lk(32'h100, 1'b1);
        set_up(1'b0, '0, 1'b0, '0, 1'b0);
        model_reset();
        @(negedge clk);
        settle();
        check("in-reset predict_taken", 32'(predict_taken), 32'h0);
        check("in-reset predict_target", predict_target, 32'h104);
        tick();
        rst = 1'b0;
        settle();
        check("reset predict_taken", 32'(predict_taken), 32'h0);
        check("reset predict_target", predict_target, 32'h104);
        check("reset mispredict_cnt", 32'(mispredict_cnt), 32'h0);

`ifndef BP_GHR_EN
        // Allocate taken, then strengthen: 2 then 3.
        set_up(1'b1, 32'h100, 1'b1, 32'h80, 1'b0);
        settle();
        check("first update same-cycle taken", 32'(predict_taken), 32'h0);
        tick();
        settle();
        check("ctr2 predict_taken", 32'(predict_taken), 32'h1);
        check("ctr2 predict_target", predict_target, 32'h80);
        tick();
        // Three not-taken updates: 3 -> 2 -> 1 -> 0.
        set_up(1'b1, 32'h100, 1'b0, 32'hDEAD, 1'b0);
        for (int k = 0; k < 3; k++) begin
            settle();
            tick();
        end
        settle();
        check("ctr0 predict_taken", 32'(predict_taken), 32'h0);
        check("ctr0 predict_target", predict_target, 32'h104);
        tick();  // attempted underflow
        set_up(1'b1, 32'h100, 1'b1, 32'h80, 1'b0);
        settle();
        tick();  // counter 1 unless it wrapped
        settle();
        check("ctr1 same-cycle predict_taken", 32'(predict_taken), 32'h0);
        tick();
        set_up(1'b0, 32'h100, 1'b1, 32'h80, 1'b0);
        settle();
        check("ctr2 next-cycle predict_taken", 32'(predict_taken), 32'h1);
        tick();
        // Alias at the same index evicts the older entry.
        set_up(1'b1, 32'h200, 1'b1, 32'h300, 1'b0);
        settle();
        tick();
        set_up(1'b0, '0, 1'b0, '0, 1'b1);
        settle();
        check("evicted predict_taken", 32'(predict_taken), 32'h0);
        check("evicted predict_target", predict_target, 32'h104);
        tick();
        set_lk(32'h200, 1'b1);
        settle();
        check("alias hit predict_taken", 32'(predict_taken), 32'h1);
        check("alias hit predict_target", predict_target, 32'h300);
        set_lk(32'h200, 1'b0);
        settle();
        check("non-branch predict_taken", 32'(predict_taken), 32'h0);
        check("non-branch predict_target", predict_target, 32'h204);
        set_lk(32'hFFFF_FFFC, 1'b1);
        settle();
        check("wrap predict_target", predict_target, 32'h0);
        tick();
        settle();
        check("mispredict without valid", 32'(mispredict_cnt), 32'h0);
        tick();
`else
        // Build GHR=11, then a taken update at 0x10 lands at index 4^3=7.
        set_up(1'b1, 32'h20, 1'b1, 32'h24, 1'b0);
        settle();
        tick();
        settle();
        tick();
        set_up(1'b1, 32'h10, 1'b1, 32'h40, 1'b0);
        set_lk(32'h10, 1'b1);
        settle();
        tick();
        set_up(1'b0, '0, 1'b0, '0, 1'b0);
        settle();
        check("ghr11 predict_taken", 32'(predict_taken), 32'h1);
        check("ghr11 predict_target", predict_target, 32'h40);
        check("ghr11 model slot 7", 32'(m_valid[7]), 32'h1);
        set_up(1'b1, 32'h400, 1'b0, '0, 1'b0);
        settle();
        tick();
        set_up(1'b0, '0, 1'b0, '0, 1'b0);
        settle();
        check("ghr10 predict_taken", 32'(predict_taken), 32'h0);
        check("ghr10 predict_target", predict_target, 32'h14);
        tick();
`endif

        // Randomized traffic, with occasional asynchronous reset cycles.
        for (int n = 0; n < 2000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            if (rst) model_reset();
            set_lk(rand_pc(), 1'($urandom_range(0, 3) != 0));
            set_up(1'($urandom_range(0, 2) != 0), rand_pc(), 1'($urandom), $urandom,
                   1'($urandom));
            settle();
            tick();
        end
        rst = 1'b0;

        // Drive the mispredict counter to just below saturation.
        while (m_cnt < 32'hFFFE) begin
            set_up(1'b1, rand_pc(), 1'($urandom), $urandom, 1'b1);
            settle();
            tick();
        end
        set_up(1'b0, '0, 1'b0, '0, 1'b0);
        settle();
        check("cnt preset", 32'(mispredict_cnt), 32'hFFFE);
        set_up(1'b1, 32'h100, 1'b0, '0, 1'b1);
        tick();
        settle();
        check("cnt reaches max", 32'(mispredict_cnt), 32'hFFFF);
        tick();
        settle();
        check("cnt holds max", 32'(mispredict_cnt), 32'hFFFF);
        tick();

        // Reset asserted mid-cycle during an update: outputs clear without a clock edge.
        set_up(1'b1, 32'h300, 1'b1, 32'h500, 1'b1);
        set_lk(32'h300, 1'b1);
        settle();
        tick();
        settle();
        check("pre-reset hit", 32'(predict_taken), 32'h1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        compare();
        check("async reset predict_taken", 32'(predict_taken), 32'h0);
        check("async reset predict_target", predict_target, 32'h304);
        check("async reset mispredict_cnt", 32'(mispredict_cnt), 32'h0);
        tick();
        settle();
        tick();
        rst = 1'b0;
        set_up(1'b0, '0, 1'b0, '0, 1'b0);
        settle();
        check("post-reset predict_taken", 32'(predict_taken), 32'h0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter PC_W, default 32, PC width in bits.
REQ-002 Parameter ENTRIES, default 64, table depth; power of two, >=4; any other value SHALL stop elaboration with an error.
REQ-003 Parameter CTR_W, default 2, saturating counter width, range 1..4.
REQ-004 Parameter GHR_W, default 6, global history width, <= log2(ENTRIES); used only under BP_GHR_EN.
REQ-005 clk  input  1  sole clock; all state changes on the rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 lookup_pc  input  PC_W  PC of the instruction in IF.
REQ-008 lookup_is_branch  input  1  IF instruction is a conditional branch (opcode 1100011).
REQ-009 predict_taken  output  1  combinational taken prediction for lookup_pc.
REQ-010 predict_target  output  PC_W  combinational next-PC prediction.
REQ-011 update_valid  input  1  a conditional branch resolved in EX this cycle.
REQ-012 update_pc  input  PC_W  PC of the resolved branch.
REQ-013 update_taken  input  1  actual outcome of the resolved branch.
REQ-014 update_target  input  PC_W  computed branch target of the resolved branch.
REQ-015 update_mispredict  input  1  resolved outcome differed from the prediction (flush).
REQ-016 mispredict_cnt  output  16  saturating count of update_mispredict events.

Function
REQ-017 IDX_W = log2(ENTRIES); each entry holds valid, tag = pc[PC_W-1:IDX_W+2], CTR_W-bit counter, PC_W-bit target.
REQ-018 Index = pc[IDX_W+1:2]; pc[1:0] are ignored.
REQ-019 Hit = valid AND stored tag equals the lookup tag.
REQ-020 predict_taken = lookup_is_branch AND hit AND counter MSB = 1; zero-cycle latency.
REQ-021 predict_target = stored target when predict_taken = 1, else lookup_pc+4 modulo 2^PC_W (0xFFFFFFFC -> 0x00000000).
REQ-022 On update_valid with a hit: counter increments when update_taken = 1 and saturates at 2^CTR_W-1; decrements when update_taken = 0 and saturates at 0; target is rewritten when update_taken = 1.
REQ-023 On update_valid with a miss: entry is allocated (valid=1, tag written, any older entry at that index evicted); counter = weakly taken (MSB 1, rest 0) if update_taken, else weakly not-taken (MSB 0, rest 1); target written only if update_taken.
REQ-024 CTR_W = 1: weakly taken = 1, weakly not-taken = 0.
REQ-025 Lookup and update on the same index in the same cycle: the lookup sees the pre-update entry; no bypass; the new value is visible on the next cycle.
REQ-026 update_valid = 0: table unchanged regardless of the other update inputs.
REQ-027 mispredict_cnt increments by 1 on each clock edge with update_valid AND update_mispredict; it holds at 0xFFFF.
REQ-028 update_mispredict without update_valid is ignored.

Reset
REQ-029 rst = 1 SHALL immediately clear all valid bits, set every counter to weakly not-taken, clear the GHR and clear mispredict_cnt, including mid-update.
REQ-030 During and after reset until the first update: predict_taken = 0 and predict_target = lookup_pc+4.

Configuration
REQ-031 Macro BP_GHR_EN defined: a GHR_W-bit non-speculative global history register shifts in update_taken (LSB) on every update_valid edge; lookup and update indices are pc[IDX_W+1:2] XOR zero-extended GHR, both using the current GHR.
REQ-032 Macro BP_GHR_EN undefined: no GHR is built, indexing is per REQ-018, and GHR_W has no effect.

Verification
REQ-033 Reset, lookup_pc=0x100, lookup_is_branch=1 -> predict_taken=0, predict_target=0x104, mispredict_cnt=0.
REQ-034 Two updates pc=0x100, taken=1, target=0x80 (CTR_W=2) -> counter 2 then 3; lookup 0x100 -> predict_taken=1, predict_target=0x80; three not-taken updates -> counter 0, no underflow, predict_taken=0.
REQ-035 Update pc=0x100 taken, then update pc=0x200 taken (same index, ENTRIES=64) -> lookup 0x100 misses (predict_taken=0); lookup 0x200 hits.
REQ-036 Same cycle: lookup 0x100 and taken update 0x100 on an entry at counter 1 -> predict_taken=0 this cycle, 1 the next cycle.
REQ-037 mispredict_cnt preset to 0xFFFE via 2 more mispredicts plus 1 extra -> stays 0xFFFF; rst asserted mid-update -> all outputs return to REQ-033 values without waiting for a clock edge.
REQ-038 With BP_GHR_EN, GHR_W=2: after taken, taken updates (GHR=2'b11), a taken update at pc=0x10 writes index 4^3=7; lookup 0x10 hits only while GHR=2'b11.
